seq_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a PAT_W-bit pattern via a valid/ready request, then shifts it out MSB-first, one bit per clock, a programmable number of times with a programmable idle gap between repetitions. It is the generating end of the serial bit-stream interface consumed by the team's Mealy sequence detectors, such as the 1011 detector. It is used both as the stimulus source in loop-back tests and as an in-system pattern emitter.

---
 rtl/seq_pattern_tx_if.sv | 28 ++
 rtl/seq_pattern_tx.sv | 166 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: request handshake and serial output bundle of the
// pattern transmitter. The requester drives the master side and the
// transmitter drives the slave side.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, pattern, repeat_cnt, gap_len,
    input  start_ready, out, out_valid, busy, done
  );

  modport slave (
    input  start_valid, pattern, repeat_cnt, gap_len,
    output start_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter. A pattern accepted over the
// valid/ready request is shifted out MSB-first, one bit per clock, a
// programmable number of times with a programmable idle gap between
// repetitions. Every output is a register, so the bit shown on out is
// prepared one edge ahead of the cycle in which it appears.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave txIf
);

  localparam int               BCW      = $clog2(PAT_W) + 1;
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(PAT_W - 1);
  localparam logic [BCW-1:0]   BIT_ONE  = BCW'(1);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  // SEND means out currently carries a pattern bit; GAP means an idle
  // cycle between repetitions is currently on the line.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [PAT_W-1:0] shift_q,      shift_d;
  logic [PAT_W-1:0] pat_q,        pat_d;
  logic [GAP_W-1:0] gapLen_q,     gapLen_d;
  logic [GAP_W-1:0] gapCnt_q,     gapCnt_d;
  logic [CNT_W-1:0] repLeft_q,    repLeft_d;
  logic [BCW-1:0]   bitCnt_q,     bitCnt_d;
  logic             out_q,        out_d;
  logic             outValid_q,   outValid_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             startReady_q, startReady_d;

  // shift_q keeps the bit on the line at its MSB; bitCnt_q is the index of
  // that bit within the current repetition; repLeft_q counts repetitions
  // still owed, including the one in flight.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    pat_d        = pat_q;
    gapLen_d     = gapLen_q;
    gapCnt_d     = gapCnt_q;
    repLeft_d    = repLeft_q;
    bitCnt_d     = bitCnt_q;
    out_d        = out_q;
    outValid_d   = outValid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    startReady_d = startReady_q;

    unique case (state_q)
      IDLE: begin
        if (txIf.start_valid && startReady_q) begin
          pat_d        = txIf.pattern;
          gapLen_d     = txIf.gap_len;
          repLeft_d    = (txIf.repeat_cnt == '0) ? ONE_REP : txIf.repeat_cnt;
          shift_d      = txIf.pattern;
          bitCnt_d     = '0;
          gapCnt_d     = '0;
          out_d        = txIf.pattern[PAT_W-1];
          outValid_d   = 1'b1;
          busy_d       = 1'b1;
          startReady_d = 1'b0;
          state_d      = SEND;
        end
      end

      SEND: begin
        if (bitCnt_q == LAST_BIT) begin
          if (repLeft_q > ONE_REP) begin
            repLeft_d = repLeft_q - ONE_REP;
            bitCnt_d  = '0;
            if (gapLen_q != '0) begin
              gapCnt_d   = gapLen_q;
              out_d      = 1'b0;
              outValid_d = 1'b0;
              state_d    = GAP;
            end else begin
              shift_d    = pat_q;
              out_d      = pat_q[PAT_W-1];
              outValid_d = 1'b1;
            end
          end else begin
            repLeft_d    = '0;
            bitCnt_d     = '0;
            shift_d      = '0;
            out_d        = 1'b0;
            outValid_d   = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            startReady_d = 1'b1;
            state_d      = IDLE;
          end
        end else begin
          shift_d  = shift_q << 1;
          bitCnt_d = bitCnt_q + BIT_ONE;
          out_d    = shift_q[PAT_W-2];
        end
      end

      GAP: begin
        if (gapCnt_q <= GAP_ONE) begin
          gapCnt_d   = '0;
          shift_d    = pat_q;
          bitCnt_d   = '0;
          out_d      = pat_q[PAT_W-1];
          outValid_d = 1'b1;
          state_d    = SEND;
        end else begin
          gapCnt_d = gapCnt_q - GAP_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any stream in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      pat_q        <= '0;
      gapLen_q     <= '0;
      gapCnt_q     <= '0;
      repLeft_q    <= '0;
      bitCnt_q     <= '0;
      out_q        <= 1'b0;
      outValid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      startReady_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      pat_q        <= pat_d;
      gapLen_q     <= gapLen_d;
      gapCnt_q     <= gapCnt_d;
      repLeft_q    <= repLeft_d;
      bitCnt_q     <= bitCnt_d;
      out_q        <= out_d;
      outValid_q   <= outValid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      startReady_q <= startReady_d;
    end
  end

  assign txIf.start_ready = startReady_q;
  assign txIf.out         = out_q;
  assign txIf.out_valid   = outValid_q;
  assign txIf.busy        = busy_q;
  assign txIf.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for the serial pattern transmitter.
// The driver turns each accepted request into the expected bit stream,
// busy length and done cycle; a monitor consumes them as the DUT emits.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int bitQ[$];
  int lenQ[$];
  int doneCycQ[$];

  int   busyCount = 0;
  logic prevBusy  = 1'b0;
  logic prevDone  = 1'b0;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) txIf ();

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .txIf (txIf)
  );

  // Free-running clock and cycle index (cycle j is the interval after edge j).
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops expected bits on every valid output and closes a stream on done.
  always @(negedge clk) begin
    if (rst) begin
      bitQ.delete();
      lenQ.delete();
      doneCycQ.delete();
      busyCount = 0;
      prevBusy  = 1'b0;
      prevDone  = 1'b0;
    end else begin
      if (txIf.busy) busyCount++;
      if (txIf.out_valid) begin
        if (bitQ.size() == 0) checkOutput("extra_valid_bit", int'(txIf.out_valid), 0);
        else checkOutput("out_bit", int'(txIf.out), bitQ.pop_front());
      end else if (txIf.busy) begin
        checkOutput("gap_out_low", int'(txIf.out), 0);
      end
      if (prevBusy && !txIf.busy) checkOutput("done_after_busy", int'(txIf.done), 1);
      if (txIf.done) begin
        checkOutput("done_one_cycle", int'(prevDone), 0);
        if (doneCycQ.size() == 0) begin
          checkOutput("spurious_done", int'(txIf.done), 0);
        end else begin
          checkOutput("done_cycle", cyc, doneCycQ.pop_front());
          checkOutput("busy_cycles", busyCount, lenQ.pop_front());
          checkOutput("bits_left_at_done", bitQ.size(), 0);
          checkOutput("ready_at_done", int'(txIf.start_ready), 1);
          checkOutput("valid_at_done", int'(txIf.out_valid), 0);
          checkOutput("out_at_done", int'(txIf.out), 0);
        end
        busyCount = 0;
      end
      prevBusy = txIf.busy;
      prevDone = txIf.done;
    end
  end

  // Present one request, wait for acceptance and record what it must produce.
  task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rc,
                               input logic [GAP_W-1:0] gl, input bit holdValid);
    int waited;
    int reps;
    int n;
    waited = 0;
    @(negedge clk);
    #1;
    txIf.pattern     = pat;
    txIf.repeat_cnt  = rc;
    txIf.gap_len     = gl;
    txIf.start_valid = 1'b1;
    while (!txIf.start_ready && waited < 1000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!txIf.start_ready) begin
      checkOutput("ready_timeout", int'(txIf.start_ready), 1);
      txIf.start_valid = 1'b0;
      return;
    end
    reps = (rc == '0) ? 1 : int'(rc);
    n    = reps * PAT_W + (reps - 1) * int'(gl);
    for (int r = 0; r < reps; r++)
      for (int b = PAT_W - 1; b >= 0; b--)
        bitQ.push_back(int'(pat[b]));
    lenQ.push_back(n);
    doneCycQ.push_back(cyc + 1 + n);
    @(posedge clk);
    #1;
    txIf.pattern     = PAT_W'($urandom);
    txIf.repeat_cnt  = CNT_W'($urandom);
    txIf.gap_len     = GAP_W'($urandom);
    txIf.start_valid = holdValid;
    @(negedge clk);
    checkOutput("ready_low_after_accept", int'(txIf.start_ready), 0);
    checkOutput("busy_after_accept", int'(txIf.busy), 1);
    checkOutput("first_bit_valid", int'(txIf.out_valid), 1);
  endtask

  // Global watchdog so a stuck design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases first, then a mid-stream reset, then randomized requests.
  initial begin
    int waited;
    txIf.start_valid = 1'b0;
    txIf.pattern     = '0;
    txIf.repeat_cnt  = '0;
    txIf.gap_len     = '0;
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_out", int'(txIf.out), 0);
    checkOutput("reset_out_valid", int'(txIf.out_valid), 0);
    checkOutput("reset_busy", int'(txIf.busy), 0);
    checkOutput("reset_done", int'(txIf.done), 0);
    checkOutput("reset_ready", int'(txIf.start_ready), 1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    applyStimulus(4'b1011, 4'd1, 4'd0, 1'b0);
    applyStimulus(4'b1011, 4'd3, 4'd0, 1'b0);
    applyStimulus(4'b1011, 4'd2, 4'd2, 1'b1);
    applyStimulus(4'b1011, 4'd0, 4'd0, 1'b0);
    applyStimulus(4'b0110, 4'd2, 4'd1, 1'b1);
    applyStimulus(4'b1001, 4'd1, 4'd7, 1'b0);

    applyStimulus(4'b1011, 4'd3, 4'd0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out", int'(txIf.out), 0);
    checkOutput("midrst_out_valid", int'(txIf.out_valid), 0);
    checkOutput("midrst_busy", int'(txIf.busy), 0);
    checkOutput("midrst_done", int'(txIf.done), 0);
    checkOutput("midrst_ready", int'(txIf.start_ready), 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(4'b1011, 4'd1, 4'd0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(PAT_W'($urandom), CNT_W'($urandom_range(0, 5)),
                    GAP_W'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    txIf.start_valid = 1'b0;

    waited = 0;
    while (doneCycQ.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_pending_streams", doneCycQ.size(), 0);
    repeat (3) @(negedge clk);
    checkOutput("idle_ready_at_end", int'(txIf.start_ready), 1);
    checkOutput("idle_busy_at_end", int'(txIf.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
